// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W      = 4;
  localparam int unsigned MC_LAT_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic {
    RUN,
    MC_WAIT
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and multi-cycle
// execute holds, plus saturating stall/flush statistics.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = MC_LAT_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_flush,
  input  logic             ex_multi,
  input  logic             stat_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ex_hold,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The first execute cycle is spent in RUN, so MC_WAIT covers MC_LAT-2 cycles.
  localparam logic [3:0] McLoad = 4'(MC_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] mc_cnt_q, mc_cnt_d;
  logic       lu;
  logic       flush_acc;

  assign lu = ex_is_load & ((id_use1 & (id_src1 == ex_dest)) |
                            (id_use2 & (id_src2 == ex_dest)));

  always_comb begin
    state_d    = state_q;
    mc_cnt_d   = mc_cnt_q;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    ex_hold    = 1'b0;
    busy       = 1'b0;
    flush_acc  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_flush) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_acc  = 1'b1;
        end else if (ex_multi) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          ex_hold  = 1'b1;
          mc_cnt_d = McLoad;
          state_d  = MC_WAIT;
        end else if (lu) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MC_WAIT: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        ex_hold = 1'b1;
        busy    = 1'b1;
        if (mc_cnt_q == 4'd1) begin
          state_d = RUN;
        end else begin
          mc_cnt_d = mc_cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (~pc_we),
    .clr  (stat_clr),
    .cnt  (stall_cnt)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (flush_acc),
    .clr  (stat_clr),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: combinational decode table plus multi-cycle sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_src1, id_src2, ex_dest;
  logic        id_use1, id_use2, ex_is_load, ex_flush, ex_multi, stat_clr;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, busy;
  logic [15:0] stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  pipe_ctrl #(
    .MC_LAT(4),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_src1   (id_src1),
    .id_src2   (id_src2),
    .id_use1   (id_use1),
    .id_use2   (id_use2),
    .ex_is_load(ex_is_load),
    .ex_dest   (ex_dest),
    .ex_flush  (ex_flush),
    .ex_multi  (ex_multi),
    .stat_clr  (stat_clr),
    .pc_we     (pc_we),
    .ifid_we   (ifid_we),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .ex_hold   (ex_hold),
    .busy      (busy),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, busy}.
  typedef struct {
    string      name;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       use1;
    logic       use2;
    logic       is_load;
    logic [3:0] dest;
    logic       flush;
    logic       multi;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    ex_is_load = 1'b0; ex_dest = 4'd0; ex_flush = 1'b0; ex_multi = 1'b0;
    stat_clr = 1'b0;
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_dest = 4'd3; id_use1 = 1'b1; id_src1 = 4'd3;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, busy};
  endfunction

  initial begin
    vecs[0]  = '{"idle",        4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 6'b110000};
    vecs[1]  = '{"lu_src1",     4'd3, 4'd0, 1, 0, 1, 4'd3, 0, 0, 6'b000100};
    vecs[2]  = '{"lu_src2",     4'd1, 4'd5, 0, 1, 1, 4'd5, 0, 0, 6'b000100};
    vecs[3]  = '{"match_nouse", 4'd3, 4'd3, 0, 0, 1, 4'd3, 0, 0, 6'b110000};
    vecs[4]  = '{"match_noload",4'd3, 4'd0, 1, 0, 0, 4'd3, 0, 0, 6'b110000};
    vecs[5]  = '{"multi",       4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 6'b000010};
    vecs[6]  = '{"flush_all",   4'd3, 4'd0, 1, 0, 1, 4'd3, 1, 1, 6'b111100};
    vecs[7]  = '{"multi_lu",    4'd3, 4'd0, 1, 0, 1, 4'd3, 0, 1, 6'b000010};
    vecs[8]  = '{"mismatch",    4'd6, 4'd7, 1, 0, 1, 4'd7, 0, 0, 6'b110000};
    vecs[9]  = '{"flush_only",  4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 0, 6'b111100};
    vecs[10] = '{"lu_reg0",     4'd9, 4'd0, 0, 1, 1, 4'd0, 0, 0, 6'b000100};

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_outs", 32'(outs()), 32'(6'b110000));
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Held in reset the FSM stays in RUN, so each vector exercises RUN decode alone.
    for (int i = 0; i < 11; i++) begin
      id_src1 = vecs[i].src1; id_src2 = vecs[i].src2;
      id_use1 = vecs[i].use1; id_use2 = vecs[i].use2;
      ex_is_load = vecs[i].is_load; ex_dest = vecs[i].dest;
      ex_flush = vecs[i].flush; ex_multi = vecs[i].multi;
      #3;
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end
    idle();
    cyc();
    rst_n = 1'b1;

    // Load-use: one stall cycle.
    cyc();
    set_lu();
    #1;
    chk("lu_pc_we", 32'(pc_we), 32'd0);
    chk("lu_idex_flush", 32'(idex_flush), 32'd1);
    cyc();
    idle();
    #1;
    chk("lu_after_pc_we", 32'(pc_we), 32'd1);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Clear, then multi-cycle op with a flush pulse ignored in MC_WAIT.
    stat_clr = 1'b1;
    cyc();
    stat_clr = 1'b0;
    #1;
    chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    ex_multi = 1'b1;
    #1;
    chk("mc_c1", 32'(outs()), 32'(6'b000010));
    cyc();
    ex_multi = 1'b0;
    #1;
    chk("mc_c2", 32'(outs()), 32'(6'b000011));
    cyc();
    ex_flush = 1'b1;
    #1;
    chk("mc_c3_flush_ignored", 32'(outs()), 32'(6'b000011));
    cyc();
    ex_flush = 1'b0;
    #1;
    chk("mc_done", 32'(outs()), 32'(6'b110000));
    chk("mc_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("mc_flush_cnt", 32'(flush_cnt), 32'd0);

    // Flush wins over multi and load-use.
    ex_flush = 1'b1; ex_multi = 1'b1; set_lu();
    #1;
    chk("fp_outs", 32'(outs()), 32'(6'b111100));
    cyc();
    idle();
    #1;
    chk("fp_no_mcwait", 32'(busy), 32'd0);
    chk("fp_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("fp_stall_cnt", 32'(stall_cnt), 32'd3);

    // Mid-op reset abandons the multi-cycle op.
    ex_multi = 1'b1;
    cyc();
    ex_multi = 1'b0;
    #1;
    chk("mr_busy_c2", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy_rst", 32'(busy), 32'd0);
    chk("mr_stall_rst", 32'(stall_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mr_pc_we", 32'(pc_we), 32'd1);
    cyc();
    chk("mr_run_after", 32'(outs()), 32'(6'b110000));

    // Saturation of stall_cnt, then clear wins over increment.
    set_lu();
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    stat_clr = 1'b1;
    cyc();
    chk("sat_clr_wins", 32'(stall_cnt), 32'd0);
    stat_clr = 1'b0;
    cyc();
    chk("post_clr_inc", 32'(stall_cnt), 32'd1);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters SHALL be:
- MC_LAT, default 4: total execute-stage cycles of a multi-cycle ALU op; legal range 3..15.
- CNT_W, default 16: width of the statistics counters.

REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_src1  in  4  first source register of the instruction in decode.
- id_src2  in  4  second source register of the instruction in decode.
- id_use1  in  1  decode instruction reads id_src1.
- id_use2  in  1  decode instruction reads id_src2.
- ex_is_load  in  1  execute-stage instruction is a load.
- ex_dest  in  4  destination register of the execute-stage instruction.
- ex_flush  in  1  execute stage resolved a taken jump or branch.
- ex_multi  in  1  execute-stage instruction is a multi-cycle ALU op.
- stat_clr  in  1  synchronous clear of both statistics counters.
- pc_we  out  1  PC register write enable.
- ifid_we  out  1  IF/ID register write enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- ex_hold  out  1  hold the ID/EX and EX/MEM registers.
- busy  out  1  FSM is in MC_WAIT.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0.
- flush_cnt  out  CNT_W  saturating count of accepted flushes.

Function
REQ-003 The FSM SHALL have two states: RUN and MC_WAIT. It SHALL have a down-counter mc_cnt, 4 bits wide.

REQ-004 Load-use hazard lu SHALL be: ex_is_load & ((id_use1 & id_src1==ex_dest) | (id_use2 & id_src2==ex_dest)).

REQ-005 In RUN, priority SHALL be ex_flush > ex_multi > lu > normal. Outputs are combinational from state and inputs.

REQ-006 In RUN with ex_flush=1:
- pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, ex_hold=0.
- ex_multi and lu are ignored.
- The next state is RUN.

REQ-007 In RUN with ex_multi=1 and ex_flush=0:
- pc_we=0, ifid_we=0, ex_hold=1, both flushes 0.
- mc_cnt loads MC_LAT-2.
- The next state is MC_WAIT.

REQ-008 In RUN with lu=1 and no higher-priority input:
- pc_we=0, ifid_we=0, idex_flush=1, ifid_flush=0, ex_hold=0.
- The next state is RUN, so the stall lasts exactly one cycle per hazard.

REQ-009 In RUN otherwise: pc_we=1, ifid_we=1, all other control outputs 0.

REQ-010 In MC_WAIT:
- pc_we=0, ifid_we=0, ex_hold=1, both flushes 0, busy=1.
- ex_flush, ex_multi and lu are ignored.

REQ-011 In MC_WAIT with mc_cnt==1, the next state SHALL be RUN. Otherwise mc_cnt decrements.
- Net effect: ex_hold is high for exactly MC_LAT-1 consecutive cycles per multi-cycle op.
- ex_hold falls in the op's MC_LAT-th execute cycle.

REQ-012 stall_cnt SHALL increment on every cycle with pc_we=0 and saturate at all-ones.

REQ-013 flush_cnt SHALL increment on every RUN cycle with ex_flush=1 and saturate at all-ones.

REQ-014 When stat_clr=1, both counters SHALL become 0 on that clock edge. stat_clr wins over a simultaneous increment.

REQ-015 busy SHALL be 0 in RUN.

Reset
REQ-016 rst_n low SHALL asynchronously force:
- state=RUN;
- mc_cnt=0;
- stall_cnt=0 and flush_cnt=0.

REQ-017 With rst_n low and all inputs idle, outputs SHALL be:
- pc_we=1, ifid_we=1;
- ifid_flush=0, idex_flush=0, ex_hold=0, busy=0.

REQ-018 Reset asserted during MC_WAIT SHALL abandon the op. The first cycle after release SHALL be RUN.

Structure
REQ-019 A shared package pipe_ctrl_pkg SHALL hold:
- the state enum {RUN, MC_WAIT};
- REG_W=4;
- the MC_LAT and CNT_W defaults.

REQ-020 One sub-module sat_counter SHALL be used, instantiated twice. It is parameterised on width, with inputs inc and clr and an asynchronous active-low reset.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset: rst_n low with idle inputs -> pc_we=1, ifid_we=1, stall_cnt=0, flush_cnt=0, busy=0.
- Load-use: ex_is_load=1, ex_dest=3, id_use1=1, id_src1=3 for one cycle -> one cycle of pc_we=0, idex_flush=1; stall_cnt=1.
- Multi-cycle op: ex_multi=1 pulsed one cycle, MC_LAT=4 -> ex_hold high 3 cycles, busy high in cycles 2-3, pc_we low 3 cycles; stall_cnt=3.
- Flush priority: ex_flush=1 with ex_multi=1 and lu=1 in the same cycle -> ifid_flush=1, idex_flush=1, pc_we=1, no MC_WAIT entry; flush_cnt=1.
- Ignored inputs and saturation: ex_flush pulsed during MC_WAIT -> no flush outputs, flush_cnt unchanged. Separately, 65540 consecutive lu cycles -> stall_cnt=16'hFFFF; stat_clr then gives 0.
- Mid-op reset: rst_n pulsed low in MC_WAIT cycle 2 -> busy=0 immediately; after release pc_we=1.
